// File: rtl/miniRISC_pkg.sv
// miniRISC_pkg: shared constants and LSU state encoding for the KGP miniRISC datapath
package miniRISC_pkg;
    localparam int LSU_DATA_W = 32;
    localparam int IMM_W = 16;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;
endpackage

// File: rtl/sign_extend.sv
// sign_extend: replicates the top input bit to widen a two's-complement value
module sign_extend #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);
    assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};
endmodule

// File: rtl/lsu_sequencer.sv
// lsu_sequencer: load/store sequencer with wait-state timeout; optional LSU_MISALIGN_CHECK_EN rejects unaligned addresses
module lsu_sequencer
    import miniRISC_pkg::*;
#(
    parameter int DATA_W      = LSU_DATA_W,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [DATA_W-1:0] base,
    input  logic [IMM_W-1:0]  offset,
    input  logic [DATA_W-1:0] wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);
    lsu_state_t state, next;
    logic [DATA_W-1:0] off_ext, ea;
    logic [7:0] cnt;
    logic err, misal, accept;
    sign_extend #(.IN_W(IMM_W), .OUT_W(DATA_W)) u_sext (.din(offset), .dout(off_ext));
    assign ea = base + off_ext;
    assign accept = (state == IDLE) && req_valid;
`ifdef LSU_MISALIGN_CHECK_EN
    assign misal = |ea[1:0];
`else
    assign misal = 1'b0;
`endif
    // next-state selection and state-decoded handshake outputs
    always_comb begin
        next       = IDLE;
        req_ready  = state == IDLE;
        busy       = state != IDLE;
        mem_en     = state == ACCESS;
        resp_valid = state == RESP;
        resp_err   = (state == RESP) && err;
        next = (state == IDLE)   ? (req_valid ? (misal ? RESP : ACCESS) : IDLE) :
               (state == ACCESS) ? ((mem_ready || cnt == CNT_LAST) ? RESP : ACCESS) :
                                   IDLE;
    end
    // state register; reset drops any in-flight access silently
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end
    // request capture, wait-state counting and response data
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rdata     <= '0;
            cnt       <= '0;
            err       <= 1'b0;
        end else if (accept) begin
            mem_addr  <= ea;
            mem_we    <= req_is_store;
            mem_wdata <= wdata;
            cnt       <= '0;
            err       <= misal;
        end else if (state == ACCESS) begin
            if (mem_ready) begin
                if (!mem_we) rdata <= mem_rdata;
                err <= 1'b0;
            end else if (cnt == CNT_LAST) begin
                err <= 1'b1;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_lsu_sequencer.sv
// tb_lsu_sequencer: table-driven scoreboard bench for lsu_sequencer
module tb_lsu_sequencer;
    localparam int TO = 15;
    logic clk = 1'b0;
    logic rst, req_valid, req_ready, req_is_store, resp_valid, resp_err;
    logic mem_en, mem_we, mem_ready, busy;
    logic [31:0] base, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] offset;
    int n_chk = 0, n_pass = 0;

    typedef struct {
        logic        st;
        logic [31:0] base;
        logic [15:0] off;
        logic [31:0] wd;
        logic [31:0] rd;
        int          waits;
        logic [31:0] addr;
    } vec_t;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rd;
        longint      t0;
    } exp_t;

    exp_t q[$];
    exp_t me;
    logic [31:0] model_rd = '0;
    vec_t vecs[7];

    lsu_sequencer #(.DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .base(base), .offset(offset), .wdata(wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // scoreboard: every completion pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (q.size() == 0) check("resp_unexpected", 32'd1, 32'd0);
            else begin
                me = q.pop_front();
                check("resp_latency", 32'(($time + 5 - me.t0) / 10), 32'(me.lat));
                check("resp_err", {31'd0, resp_err}, {31'd0, me.err});
                check("rdata", rdata, me.rd);
            end
        end
    end

    function automatic bit is_misal(input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_exp(input vec_t v, output int en_exp);
        exp_t e;
        bit ok;
        en_exp = is_misal(v.addr) ? 0 : (v.waits >= 0 && v.waits < TO) ? v.waits + 1 : TO;
        ok = !is_misal(v.addr) && v.waits >= 0 && v.waits < TO;
        if (!v.st && ok) model_rd = v.rd;
        e.lat = en_exp + 1;
        e.err = !ok;
        e.rd  = model_rd;
        e.t0  = longint'($time);
        q.push_back(e);
    endtask

    task automatic run_vec(input vec_t v);
        int k, en_cnt, en_exp;
        bit done, stable;
        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_is_store = v.st; base = v.base; offset = v.off; wdata = v.wd;
        @(posedge clk);
        push_exp(v, en_exp);
        #1 req_valid = 1'b0;
        en_cnt = 0; k = 0; done = 0; stable = 1;
        while (!done && k < 300) begin
            mem_ready = (en_cnt == v.waits);
            mem_rdata = (en_cnt == v.waits) ? v.rd : ~v.rd;
            @(negedge clk);
            if (mem_en) begin
                if (en_cnt == 0) begin
                    check("mem_addr", mem_addr, v.addr);
                    check("mem_we", {31'd0, mem_we}, {31'd0, v.st});
                    if (v.st) check("mem_wdata", mem_wdata, v.wd);
                end
                if (mem_addr !== v.addr || mem_we !== v.st || req_ready !== 1'b0) stable = 0;
                en_cnt++;
            end
            if (resp_valid) done = 1;
            else begin @(posedge clk); #1; k++; end
        end
        mem_ready = 1'b0;
        check("resp_seen", {31'd0, done}, 32'd1);
        check("mem_en_cycles", 32'(en_cnt), 32'(en_exp));
        check("access_stable", {31'd0, stable}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int en_exp;
        vecs[0] = '{1'b0, 32'h0000_1000, 16'h0010, 32'h0, 32'hDEAD_BEEF, 0, 32'h0000_1010};
        vecs[1] = '{1'b1, 32'h0000_1000, 16'hFFFC, 32'h1234_5678, 32'hAAAA_5555, 3, 32'h0000_0FFC};
        vecs[2] = '{1'b0, 32'hFFFF_FFF0, 16'h0020, 32'h0, 32'h1111_1111, -1, 32'h0000_0010};
        vecs[3] = '{1'b0, 32'h0000_2000, 16'h8000, 32'h0, 32'hCAFE_F00D, TO - 1, 32'hFFFF_A000};
        vecs[4] = '{1'b0, 32'h0000_1000, 16'h0002, 32'h0, 32'h0BAD_F00D, 0, 32'h0000_1002};
        vecs[5] = '{1'b1, 32'h7FFF_FFFC, 16'h7FFC, 32'hA5A5_A5A5, 32'h0, 1, 32'h8000_7FF8};
        vecs[6] = '{1'b0, 32'h0000_0004, 16'hFFFC, 32'h0, 32'h1357_9BDF, 2, 32'h0000_0000};
        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; base = '0; offset = '0;
        wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        foreach (vecs[i]) run_vec(vecs[i]);

        // reset during the second ACCESS cycle: no response, access dropped
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; base = 32'h0000_3000; offset = 16'h0004;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rstmid_en1", {31'd0, mem_en}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rstmid_en2", {31'd0, mem_en}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_en_off", {31'd0, mem_en}, 32'd0);
        check("rstmid_ready", {31'd0, req_ready}, 32'd1);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_addr", mem_addr, 32'd0);
        model_rd = '0;
        repeat (3) @(negedge clk);
        run_vec(vecs[0]);

        // back-to-back: req_valid held high, second request waits out RESP
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; base = 32'h0000_0100; offset = 16'h0008;
        @(posedge clk);
        push_exp(vecs[0], en_exp);
        q[q.size()-1].rd = 32'h0102_0304;
        model_rd = 32'h0102_0304;
        #1 mem_ready = 1'b1; mem_rdata = 32'h0102_0304;
        @(negedge clk);
        check("b2b_ready_access", {31'd0, req_ready}, 32'd0);
        check("b2b_addr", mem_addr, 32'h0000_0108);
        @(posedge clk);
        #1 mem_ready = 1'b0; mem_rdata = 32'h0506_0708;
        @(negedge clk);
        check("b2b_ready_resp", {31'd0, req_ready}, 32'd0);
        check("b2b_resp1", {31'd0, resp_valid}, 32'd1);
        @(negedge clk);
        check("b2b_ready_idle", {31'd0, req_ready}, 32'd1);
        check("b2b_en_idle", {31'd0, mem_en}, 32'd0);
        @(posedge clk);
        q.push_back('{2, 1'b0, 32'h0506_0708, longint'($time)});
        model_rd = 32'h0506_0708;
        #1 req_valid = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        check("b2b_en2", {31'd0, mem_en}, 32'd1);
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        check("b2b_resp2", {31'd0, resp_valid}, 32'd1);
        repeat (3) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
